// File: rtl/maj_vote_filter_if.sv
// maj_vote_filter_if
// Groups the sample-side controls/data and the voted/fault outputs of maj_vote_filter.
//   master : producer/consumer side (drives en, clr_cnt, in_bus; observes results)
//   slave  : the filter itself
// Signals:
//   en          sample enable
//   clr_cnt     synchronous clear of fault_cnt (qualified by en)
//   in_bus      NCH channels, channel c at [c*WIDTH +: WIDTH]
//   vote_out    filtered, registered majority word
//   valid       vote_out loaded at least once since reset
//   ch_fault    per-channel disagreement with the raw vote at the last sample
//   multi_fault two or more channels faulty at the last sample
//   fault_cnt   saturating count of samples with any channel fault
interface maj_vote_filter_if #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
);
    logic                   en;
    logic                   clr_cnt;
    logic [NCH*WIDTH-1:0]   in_bus;
    logic [WIDTH-1:0]       vote_out;
    logic                   valid;
    logic [NCH-1:0]         ch_fault;
    logic                   multi_fault;
    logic [CNT_W-1:0]       fault_cnt;

    modport master (
        output en, clr_cnt, in_bus,
        input  vote_out, valid, ch_fault, multi_fault, fault_cnt
    );

    modport slave (
        input  en, clr_cnt, in_bus,
        output vote_out, valid, ch_fault, multi_fault, fault_cnt
    );
endinterface

// File: rtl/maj_vote_filter.sv
// maj_vote_filter
// Bitwise majority vote over NCH redundant WIDTH-bit channels, followed by a stability filter:
// the voted word must be sampled unchanged on HOLD consecutive enabled edges before it is
// loaded into vote_out. Also flags disagreeing channels and keeps a saturating fault count.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    maj_vote_filter_if.slave (en, clr_cnt, in_bus in; vote_out, valid, ch_fault,
//          multi_fault, fault_cnt out)
module maj_vote_filter #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned HOLD  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    maj_vote_filter_if.slave   bus
);
    localparam int unsigned      RunW    = $clog2(HOLD + 1);
    localparam logic [RunW-1:0]  HoldRun = RunW'(HOLD);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {StInit, StLocked, StPending} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [RunW-1:0]   run_q, run_d;
    logic [WIDTH-1:0]  vote_out_q, vote_out_d;
    logic [NCH-1:0]    ch_fault_q, ch_fault_d;
    logic              multi_fault_q, multi_fault_d;
    logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

    logic [WIDTH-1:0]  vote_raw;
    int unsigned       ones;
    int unsigned       n_fault;

    // Raw bitwise majority; NCH is odd so a tie cannot occur.
    always_comb begin
        vote_raw = '0;
        ones     = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = 0;
            for (int c = 0; c < NCH; c++) begin
                if (bus.in_bus[c*WIDTH + i]) ones++;
            end
            vote_raw[i] = (ones > NCH / 2);
        end
    end

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        run_d         = run_q;
        vote_out_d    = vote_out_q;
        ch_fault_d    = ch_fault_q;
        multi_fault_d = multi_fault_q;
        fault_cnt_d   = fault_cnt_q;
        n_fault       = 0;

        if (bus.en) begin
            // Stability run; a revert to vote_out while pending falls out of this naturally
            // (cand becomes vote_out, run restarts at 1).
            if (vote_raw != cand_q) begin
                cand_d = vote_raw;
                run_d  = RunW'(1);
            end else if (run_q != HoldRun) begin
                run_d = run_q + RunW'(1);
            end

            if (run_d == HoldRun) begin
                vote_out_d = cand_d;
            end

            for (int c = 0; c < NCH; c++) begin
                ch_fault_d[c] = (bus.in_bus[c*WIDTH +: WIDTH] != vote_raw);
                if (ch_fault_d[c]) n_fault++;
            end
            multi_fault_d = (n_fault >= 2);

            if (bus.clr_cnt) begin
                fault_cnt_d = '0;
            end else if ((|ch_fault_d) && (fault_cnt_q != CntMax)) begin
                fault_cnt_d = fault_cnt_q + 1'b1;
            end

            unique case (state_q)
                StInit: begin
                    if (run_d == HoldRun) state_d = StLocked;
                end
                StLocked: begin
                    if (run_d == HoldRun)            state_d = StLocked;
                    else if (vote_raw != vote_out_q) state_d = StPending;
                end
                StPending: begin
                    if (run_d == HoldRun || vote_raw == vote_out_q) state_d = StLocked;
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StInit;
            cand_q        <= '0;
            run_q         <= '0;
            vote_out_q    <= '0;
            ch_fault_q    <= '0;
            multi_fault_q <= 1'b0;
            fault_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            run_q         <= run_d;
            vote_out_q    <= vote_out_d;
            ch_fault_q    <= ch_fault_d;
            multi_fault_q <= multi_fault_d;
            fault_cnt_q   <= fault_cnt_d;
        end
    end

    assign bus.vote_out    = vote_out_q;
    assign bus.valid       = (state_q != StInit);
    assign bus.ch_fault    = ch_fault_q;
    assign bus.multi_fault = multi_fault_q;
    assign bus.fault_cnt   = fault_cnt_q;
endmodule

// File: tb/tb_maj_vote_filter.sv
// tb_maj_vote_filter
// Directed bench for maj_vote_filter with NCH=3, WIDTH=4, HOLD=3, CNT_W=2.
module tb_maj_vote_filter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    maj_vote_filter_if #(.NCH(3), .WIDTH(4), .CNT_W(2)) bus_if ();

    maj_vote_filter #(.NCH(3), .WIDTH(4), .HOLD(3), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Channel order: ch0 in the low nibble.
    task automatic drive(input logic [3:0] c2, input logic [3:0] c1, input logic [3:0] c0);
        bus_if.in_bus = {c2, c1, c0};
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] vo, input logic vl,
                             input logic [2:0] cf, input logic mf, input logic [1:0] fc);
        check_eq({tag, ".vote_out"}, 32'(bus_if.vote_out), 32'(vo));
        check_eq({tag, ".valid"}, 32'(bus_if.valid), 32'(vl));
        check_eq({tag, ".ch_fault"}, 32'(bus_if.ch_fault), 32'(cf));
        check_eq({tag, ".multi_fault"}, 32'(bus_if.multi_fault), 32'(mf));
        check_eq({tag, ".fault_cnt"}, 32'(bus_if.fault_cnt), 32'(fc));
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus_if.en      = 1'b0;
        bus_if.clr_cnt = 1'b0;
        drive(4'hA, 4'hA, 4'hA);
        #3;
        check_all("reset", 4'h0, 1'b0, 3'b000, 1'b0, 2'd0);
        step();
        rst_n     = 1'b1;
        bus_if.en = 1'b1;

        // All channels equal: loads after the third stable sample.
        step(); check_all("lock_e1", 4'h0, 1'b0, 3'b000, 1'b0, 2'd0);
        step(); check_all("lock_e2", 4'h0, 1'b0, 3'b000, 1'b0, 2'd0);
        step(); check_all("lock_e3", 4'hA, 1'b1, 3'b000, 1'b0, 2'd0);

        // Bitwise vote 1100/1010/0110 -> 1110, every channel disagrees.
        drive(4'b0110, 4'b1010, 4'b1100);
        step(); check_all("bitw_e1", 4'hA, 1'b1, 3'b111, 1'b1, 2'd1);
        step(); check_all("bitw_e2", 4'hA, 1'b1, 3'b111, 1'b1, 2'd2);
        step(); check_all("bitw_e3", 4'hE, 1'b1, 3'b111, 1'b1, 2'd3);

        // Back to A, clearing the count on the first edge.
        drive(4'hA, 4'hA, 4'hA);
        bus_if.clr_cnt = 1'b1;
        step(); check_all("back_e1", 4'hE, 1'b1, 3'b000, 1'b0, 2'd0);
        bus_if.clr_cnt = 1'b0;
        step(); check_eq("back_e2.vote_out", 32'(bus_if.vote_out), 32'hE);
        step(); check_eq("back_e3.vote_out", 32'(bus_if.vote_out), 32'hA);

        // Two-sample glitch is filtered out.
        drive(4'h3, 4'h3, 4'h3);
        step(); check_eq("glitch_e1", 32'(bus_if.vote_out), 32'hA);
        step(); check_eq("glitch_e2", 32'(bus_if.vote_out), 32'hA);
        drive(4'hA, 4'hA, 4'hA);
        step(); check_eq("glitch_rev", 32'(bus_if.vote_out), 32'hA);
        // Three-sample change is accepted.
        drive(4'h3, 4'h3, 4'h3);
        step(); check_eq("chg_e1", 32'(bus_if.vote_out), 32'hA);
        step(); check_eq("chg_e2", 32'(bus_if.vote_out), 32'hA);
        step(); check_eq("chg_e3", 32'(bus_if.vote_out), 32'h3);
        drive(4'hA, 4'hA, 4'hA);
        step(); step(); step();
        check_eq("relock_a", 32'(bus_if.vote_out), 32'hA);

        // Single faulty channel 2, count saturates at 3.
        drive(4'h5, 4'hA, 4'hA);
        step(); check_all("sf_e1", 4'hA, 1'b1, 3'b100, 1'b0, 2'd1);
        step(); check_all("sf_e2", 4'hA, 1'b1, 3'b100, 1'b0, 2'd2);
        step(); check_all("sf_e3", 4'hA, 1'b1, 3'b100, 1'b0, 2'd3);
        step(); check_all("sf_e4", 4'hA, 1'b1, 3'b100, 1'b0, 2'd3);
        step(); check_all("sf_e5", 4'hA, 1'b1, 3'b100, 1'b0, 2'd3);
        bus_if.clr_cnt = 1'b1;
        step(); check_eq("clr_prio", 32'(bus_if.fault_cnt), 32'd0);
        bus_if.clr_cnt = 1'b0;
        step(); check_eq("post_clr", 32'(bus_if.fault_cnt), 32'd1);
        bus_if.en      = 1'b0;
        bus_if.clr_cnt = 1'b1;
        step(); check_eq("clr_no_en", 32'(bus_if.fault_cnt), 32'd1);
        bus_if.en      = 1'b1;
        bus_if.clr_cnt = 1'b0;
        drive(4'hA, 4'hA, 4'hA);
        step(); check_all("no_fault", 4'hA, 1'b1, 3'b000, 1'b0, 2'd1);
        bus_if.clr_cnt = 1'b1;
        step(); check_eq("clr_clean", 32'(bus_if.fault_cnt), 32'd0);
        bus_if.clr_cnt = 1'b0;

        // Enable gating: two samples of 3, a disabled gap, then the third sample.
        drive(4'h3, 4'h3, 4'h3);
        step(); step();
        check_eq("gate_pre", 32'(bus_if.vote_out), 32'hA);
        bus_if.en = 1'b0;
        drive(4'h3, 4'h3, 4'h0);
        for (int k = 0; k < 10; k++) begin
            step(); check_all("gate_off", 4'hA, 1'b1, 3'b000, 1'b0, 2'd0);
        end
        drive(4'h3, 4'h3, 4'h3);
        bus_if.en = 1'b1;
        step(); check_eq("gate_on", 32'(bus_if.vote_out), 32'h3);

        // Asynchronous reset while pending with a fault recorded.
        drive(4'h5, 4'hA, 4'hA);
        step(); check_all("pend", 4'h3, 1'b1, 3'b100, 1'b0, 2'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'h0, 1'b0, 3'b000, 1'b0, 2'd0);
        #1;
        rst_n = 1'b1;
        drive(4'hA, 4'hA, 4'hA);
        step(); check_all("rr_e1", 4'h0, 1'b0, 3'b000, 1'b0, 2'd0);
        step(); check_all("rr_e2", 4'h0, 1'b0, 3'b000, 1'b0, 2'd0);
        step(); check_all("rr_e3", 4'hA, 1'b1, 3'b000, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/maj_vote_filter.md
Name: maj_vote_filter

Overview:
- Parametrised successor to the fixed 3-input single-bit majority gates.
- Votes NCH redundant WIDTH-bit channels bitwise.
- Filters the voted word so it must stay stable for HOLD samples before it reaches the registered output.
- Flags disagreeing channels per sample and keeps a saturating fault count. Sits between replicated sources (TMR registers or sensor lanes) and downstream consumers.

Parameters:
- NCH, 3, number of redundant channels; odd, >= 3.
- WIDTH, 1, bits per channel.
- HOLD, 2, consecutive identical vote samples required before vote_out updates; >= 1.
- CNT_W, 8, width of fault_cnt.

Ports:
- clk  in  1  clock; all registers on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample enable; registers update only on edges with en=1.
- clr_cnt  in  1  synchronous clear of fault_cnt; qualified by en.
- in_bus  in  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- vote_out  out  WIDTH  filtered, registered majority word.
- valid  out  1  vote_out has been loaded at least once since reset.
- ch_fault  out  NCH  bit c = channel c differed from raw vote at the last sample.
- multi_fault  out  1  two or more channels faulty at the last sample.
- fault_cnt  out  CNT_W  saturating count of samples with any channel fault.

Behaviour:
- Reset: rst_n=0 asynchronously forces these to 0 regardless of clk, including mid-operation:
  - outputs vote_out, valid, ch_fault, multi_fault, fault_cnt;
  - internal cand (WIDTH) and run (0..HOLD);
  - state, which goes to INIT.
- Raw vote (combinational): vote_raw[i] = 1 iff the number of channels with bit i = 1 exceeds NCH/2 (integer division).
- en=0: every register holds, including run. Disabled cycles neither break nor extend a stability run.
- On each edge with en=1:
  - If vote_raw != cand: cand <= vote_raw, run <= 1.
  - Else: run <= min(run+1, HOLD).
  - If the new run == HOLD: vote_out <= new cand and valid <= 1. Otherwise vote_out holds.
  - ch_fault[c] <= (channel c != vote_raw), comparing all WIDTH bits.
  - multi_fault <= popcount(new ch_fault) >= 2.
  - fault_cnt: clr_cnt=1 loads 0; clr_cnt has priority over an increment in the same cycle. Otherwise fault_cnt increments by 1 if any new ch_fault bit is 1, saturating at 2^CNT_W-1 with no wrap.
- Latency:
  - HOLD=1: vote_out follows vote_raw one edge after sampling.
  - General case: a new vote sampled on edge k first appears on vote_out after edge k+HOLD-1, provided it is sampled unchanged on HOLD consecutive enabled edges.
  - ch_fault, multi_fault and fault_cnt have 1-sample latency.
- State machine (state register drives valid):
  - INIT: no word accepted yet. Go to LOCKED when the new run == HOLD.
  - LOCKED: cand == vote_out. Go to PENDING on an enabled edge where vote_raw != vote_out.
  - PENDING: candidate differs from vote_out and is accumulating. Go to LOCKED when the new run == HOLD. Return to LOCKED with run=1, cand=vote_out, and no output change if vote_raw reverts to vote_out before HOLD is reached. Restart run=1 on any other new value.
- Boundaries:
  - A glitch shorter than HOLD samples never reaches vote_out.
  - run saturates at HOLD; a long stable input causes no re-load side effects.
  - Ties are impossible because NCH is odd.
  - fault_cnt saturation is permanent until clr_cnt or reset.
  - clr_cnt with en=0 has no effect.

Test Plan:
- Setup for all scenarios: NCH=3, WIDTH=4, HOLD=3, CNT_W=2.
- All channels 4'hA, en=1 for 3 edges:
  - vote_out=0, valid=0 after edges 1-2;
  - vote_out=4'hA, valid=1 after edge 3;
  - ch_fault=3'b000, fault_cnt=0.
- Bitwise vote, channels 4'b1100 / 4'b1010 / 4'b0110 for 3 edges:
  - vote_out=4'b1110;
  - ch_fault=3'b111, multi_fault=1;
  - fault_cnt=1, 2, 3 on the successive edges.
- Glitch filter, locked at 4'hA:
  - All channels 4'h3 for 2 edges, then 4'hA: vote_out stays 4'hA throughout.
  - Repeat with 4'h3 for 3 edges: vote_out=4'h3 after the third edge.
- Single-channel fault and saturation:
  - Channel 2 = 4'h5, others 4'hA, for 5 edges: vote_out holds 4'hA, ch_fault=3'b100, multi_fault=0, fault_cnt = 1, 2, 3, 3, 3.
  - clr_cnt=1 alongside the fault: fault_cnt=0 next edge.
- Enable gating: locked at 4'hA, new vote 4'h3 sampled for 2 edges, en=0 for 10 cycles, then 1 more enabled edge → vote_out=4'h3 on that edge; all outputs constant while en=0.
- Asynchronous reset: assert rst_n=0 mid-PENDING between clock edges → all outputs 0 immediately, without waiting for an edge. After release, the next update needs 3 fresh stable samples.
